dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the processor control unit (LDAC/STAC accesses through AR and AC) and a host loader port. The host port preloads operands and reads back results.
- Sits between the control unit / datapath and the data memory block. It owns the memory address, write-data and write-enable pins.
- Each access is a fixed multi-cycle transaction with a req/ack handshake. Ties are broken round-robin.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_arbiter_rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: grant-state encoding,
// requester identifiers and the default access length.
package dmem_pkg;

  // Grant-state encoding for the arbiter FSM.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } state_t;

  // Requester identifiers; also the bit index into the eligible vector.
  localparam logic CPU  = 1'b0;
  localparam logic HOST = 1'b1;

  // Default number of cycles an access holds the memory.
  localparam int ACC_CYCLES_DEF = 2;

  // Maps a requester id to the grant state that serves it.
  function automatic state_t gnt_state(input logic id);
    return (id == HOST) ? GNT_HOST : GNT_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker. Purely combinational; the caller keeps
// last_grant in a register and updates it when a grant is taken.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] eligible,    // [0] = CPU, [1] = HOST
  input  logic       last_grant,  // id of the most recently granted side
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Single requester wins outright; on a tie the side not served last wins.
  always_comb begin
    gnt_valid = |eligible;
    gnt_id    = CPU;
    if (eligible == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (eligible[HOST]) begin
      gnt_id = HOST;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU control unit
// (LDAC/STAC via AR/AC) and the host loader port. Each access is a fixed
// ACC_CYCLES transaction; ties are broken round-robin.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata valid and
// holds them until x_ack. Inputs are sampled once, at the grant edge; later
// changes (including dropping x_req) do not abort the access. x_ack is a
// one-cycle pulse; x_rdata is valid with it on reads and held until the next
// read on that side completes. In the ack cycle that requester is masked, so
// a still-high req is not immediately re-granted.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int ACC_CYCLES = ACC_CYCLES_DEF  // must be >= 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic [1:0]       eligible;
  logic             gnt_valid;
  logic             gnt_id;

  // A side being acked this cycle is not eligible for a new grant.
  always_comb begin
    eligible = {host_req & ~host_ack, cpu_req & ~cpu_ack};
  end

  rr_arb2 u_rr_arb2 (
    .eligible   (eligible),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Busy whenever a transaction owns the memory.
  always_comb begin
    busy = (state != IDLE);
  end

  // Grant FSM: grant from IDLE, hold the memory for ACC_CYCLES, then ack.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= HOST;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          cnt    <= '0;
          if (gnt_valid) begin
            state      <= gnt_state(gnt_id);
            last_grant <= gnt_id;
            if (gnt_id == HOST) begin
              mem_addr  <= host_addr;
              mem_wdata <= host_wdata;
              mem_we    <= host_we;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_we    <= cpu_we;
            end
          end
        end
        GNT_CPU, GNT_HOST: begin
          if (cnt == CNT_LAST) begin
            // mem_we still reflects the granted access type here.
            state  <= IDLE;
            cnt    <= '0;
            mem_we <= 1'b0;
            if (state == GNT_CPU) begin
              cpu_ack <= 1'b1;
              if (!mem_we) cpu_rdata <= mem_rdata;
            end else begin
              host_ack <= 1'b1;
              if (!mem_we) host_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a cycle-by-cycle vector table for isolated
// accesses, then hand-written sequences for ties, reset and withdrawal.
module tb_dmem_arbiter;

  logic       CLK;
  logic       RESET;
  logic       cpu_req, cpu_we, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       host_req, host_we, host_ack;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       busy;

  int checks;
  int failures;

  logic [7:0] tb_mem [256];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .ACC_CYCLES(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural single-port memory: async read, write on rising edge.
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge CLK) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic       rst;
    logic       cr;
    logic       cw;
    logic [7:0] ca;
    logic [7:0] cd;
    logic       hr;
    logic       hw;
    logic [7:0] ha;
    logic [7:0] hd;
    logic       e_cack;
    logic       e_hack;
    logic       e_we;
    logic [7:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_busy;
    logic [7:0] e_crd;
    logic [7:0] e_hrd;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %0h want %0h", name, tag, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    tb_mem[8'h10] = 8'h5A;

    // Row inputs are driven for one cycle; expectations are the outputs in the next cycle.
    //          rst cr cw ca     cd     hr hw ha     hd     | cack hack we addr  wdata busy crd    hrd
    vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
    vecs[1]  = '{0, 1, 0, 8'h10, 8'h77, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h10, 8'h77, 1, 8'h00, 8'h00};
    vecs[2]  = '{0, 1, 0, 8'h10, 8'h77, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h10, 8'h77, 1, 8'h00, 8'h00};
    vecs[3]  = '{0, 1, 0, 8'h10, 8'h77, 0, 0, 8'h00, 8'h00,  1, 0, 0, 8'h10, 8'h77, 0, 8'h5A, 8'h00};
    vecs[4]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h10, 8'h77, 0, 8'h5A, 8'h00};
    vecs[5]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3,  0, 0, 1, 8'h20, 8'hC3, 1, 8'h5A, 8'h00};
    vecs[6]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3,  0, 0, 1, 8'h20, 8'hC3, 1, 8'h5A, 8'h00};
    vecs[7]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3,  0, 1, 0, 8'h20, 8'hC3, 0, 8'h5A, 8'h00};
    vecs[8]  = '{0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h20, 8'h00, 1, 8'h5A, 8'h00};
    vecs[9]  = '{0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h20, 8'h00, 1, 8'h5A, 8'h00};
    vecs[10] = '{0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00,  1, 0, 0, 8'h20, 8'h00, 0, 8'hC3, 8'h00};
    vecs[11] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h20, 8'h00, 0, 8'hC3, 8'h00};
    vecs[12] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h11,  0, 0, 0, 8'h10, 8'h11, 1, 8'hC3, 8'h00};
    vecs[13] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h11,  0, 0, 0, 8'h10, 8'h11, 1, 8'hC3, 8'h00};
    vecs[14] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h11,  0, 1, 0, 8'h10, 8'h11, 0, 8'hC3, 8'h5A};
    vecs[15] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00,  0, 0, 0, 8'h10, 8'h11, 0, 8'hC3, 8'h5A};

    // Table: reset state, isolated CPU read, host write, read-back, host read.
    for (int i = 0; i < 16; i++) begin
      RESET = vecs[i].rst;
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].hr, vecs[i].hw, vecs[i].ha, vecs[i].hd);
      tick();
      chk("tbl_cpu_ack",    i, 32'(cpu_ack),    32'(vecs[i].e_cack));
      chk("tbl_host_ack",   i, 32'(host_ack),   32'(vecs[i].e_hack));
      chk("tbl_mem_we",     i, 32'(mem_we),     32'(vecs[i].e_we));
      chk("tbl_mem_addr",   i, 32'(mem_addr),   32'(vecs[i].e_addr));
      chk("tbl_mem_wdata",  i, 32'(mem_wdata),  32'(vecs[i].e_wdata));
      chk("tbl_busy",       i, 32'(busy),       32'(vecs[i].e_busy));
      chk("tbl_cpu_rdata",  i, 32'(cpu_rdata),  32'(vecs[i].e_crd));
      chk("tbl_host_rdata", i, 32'(host_rdata), 32'(vecs[i].e_hrd));
    end
    RESET = 1'b0;

    // Simultaneous requests after reset, then sustained ties: acks every
    // 3 cycles alternating CPU (cycle 3), HOST (6), CPU (9), ...
    do_reset();
    drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
    for (int c = 1; c <= 30; c++) begin
      logic exp_c, exp_h;
      tick();
      exp_c = ((c % 3) == 0) && (((c / 3) % 2) == 1);
      exp_h = ((c % 3) == 0) && (((c / 3) % 2) == 0);
      chk("tie_cpu_ack",  c, 32'(cpu_ack),  32'(exp_c));
      chk("tie_host_ack", c, 32'(host_ack), 32'(exp_h));
      if (c == 1) chk("tie_first_gnt_addr", c, 32'(mem_addr), 32'h10);
      if (c == 4) chk("tie_second_gnt_addr", c, 32'(mem_addr), 32'h20);
      if (exp_c) chk("tie_cpu_rdata", c, 32'(cpu_rdata), 32'h5A);
      if (exp_h) chk("tie_host_rdata", c, 32'(host_rdata), 32'hC3);
      if (c == 30) drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    end
    tick();
    chk("tie_drain_busy", 0, 32'(busy), 32'h0);

    // Reset in the middle of a host write.
    do_reset();
    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h99);
    tick();
    chk("rst_mid_we_c1", 1, 32'(mem_we), 32'h1);
    tick();
    RESET = 1'b1;
    tick();
    chk("rst_mid_we_c3",    3, 32'(mem_we),    32'h0);
    chk("rst_mid_busy_c3",  3, 32'(busy),      32'h0);
    chk("rst_mid_hack_c3",  3, 32'(host_ack),  32'h0);
    chk("rst_mid_addr_c3",  3, 32'(mem_addr),  32'h0);
    chk("rst_mid_wdata_c3", 3, 32'(mem_wdata), 32'h0);
    RESET = 1'b0;
    drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
    tick();
    chk("rst_tie_cpu_addr", 4, 32'(mem_addr), 32'h10);
    chk("rst_tie_busy",     4, 32'(busy),     32'h1);
    begin
      bit got_ack;
      got_ack = 1'b0;
      for (int k = 0; k < 8 && !got_ack; k++) begin
        tick();
        chk("rst_tie_no_hack", k, 32'(host_ack), 32'h0);
        if (cpu_ack) begin
          got_ack = 1'b1;
          drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        end
      end
      chk("rst_tie_cpu_ack_seen", 0, 32'(got_ack), 32'h1);
      drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    end
    tick();
    chk("rst_tie_idle", 0, 32'(busy), 32'h0);

    // CPU drops req mid-grant; pending host request follows at cycle 4.
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("wd_cpu_ack_c3",   3, 32'(cpu_ack),   32'h1);
    chk("wd_cpu_rdata_c3", 3, 32'(cpu_rdata), 32'h5A);
    chk("wd_host_ack_c3",  3, 32'(host_ack),  32'h0);
    tick();
    chk("wd_host_addr_c4", 4, 32'(mem_addr), 32'h20);
    chk("wd_busy_c4",      4, 32'(busy),     32'h1);
    chk("wd_cpu_ack_c4",   4, 32'(cpu_ack),  32'h0);
    tick();
    tick();
    chk("wd_host_ack_c6",   6, 32'(host_ack),   32'h1);
    chk("wd_host_rdata_c6", 6, 32'(host_rdata), 32'hC3);
    host_req = 1'b0;
    tick();
    chk("wd_idle_c7",      7, 32'(busy),     32'h0);
    chk("wd_host_ack_c7",  7, 32'(host_ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
